// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl
//   Sequences one operand block into the skewing FIFO bank. It reads DIM rows
//   from operand memory and pushes them one per shift. It then pushes DRAIN
//   zero rows so every lane empties, and pulses done. Back-pressure (stall_in)
//   freezes reads and pushes. A read that is already in flight when a stall
//   starts is parked in a one-entry hold register, so no row is lost.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               begin a block (only looked at in IDLE)
//   stall_in            downstream back-pressure
//   rd_en, rd_addr      operand memory read request
//   rd_data             row data, valid one cycle after rd_en
//   fifo_en, fifo_stall shift / stall strobes to every FIFO in the bank
//   fifo_d              row pushed into the bank (zero when not pushing)
//   busy, done          block in progress / one-cycle end-of-block pulse
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_FILL  | issuing row reads and pushing returned rows
// S_DRAIN | pushing zero rows until the bank has flushed
// S_DONE  | one-cycle done pulse, then back to idle

module skew_feed_ctrl #(
  parameter int DIM    = 8,
  parameter int BITS   = 8,
  parameter int ADDR_W = 3,
  parameter int DRAIN  = 2*DIM-1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                stall_in,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [DIM*BITS-1:0] rd_data,
  output logic                fifo_en,
  output logic                fifo_stall,
  output logic [DIM*BITS-1:0] fifo_d,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(DIM+1);
  localparam int DC_W  = $clog2(DRAIN+1);

  localparam logic [CNT_W-1:0] ROWS       = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] LAST_ROW   = CNT_W'(DIM-1);
  localparam logic [DC_W-1:0]  LAST_DRAIN = DC_W'(DRAIN-1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]    push_cnt, push_cnt_nxt;
  logic [DC_W-1:0]     drain_cnt, drain_cnt_nxt;
  logic                rd_vld;
  logic                hold_vld, hold_vld_nxt;
  logic [DIM*BITS-1:0] hold_q, hold_nxt;
  logic                push_row;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rd_ptr    <= '0;
      push_cnt  <= '0;
      drain_cnt <= '0;
      rd_vld    <= 1'b0;
      hold_vld  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_ptr    <= rd_ptr_nxt;
      push_cnt  <= push_cnt_nxt;
      drain_cnt <= drain_cnt_nxt;
      // rd_data is valid the cycle after a read strobe; a reset above kills
      // any read still in flight.
      rd_vld    <= rd_en;
      hold_vld  <= hold_vld_nxt;
    end
  end

  // Hold data needs no reset: it is only consumed while hold_vld is set.
  always_ff @(posedge clk) begin
    hold_q <= hold_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rd_ptr_nxt    = rd_ptr;
    push_cnt_nxt  = push_cnt;
    drain_cnt_nxt = drain_cnt;
    hold_vld_nxt  = hold_vld;
    hold_nxt      = hold_q;
    push_row      = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    fifo_en       = 1'b0;
    fifo_d        = '0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_FILL;
          rd_ptr_nxt    = '0;
          push_cnt_nxt  = '0;
          drain_cnt_nxt = '0;
          hold_vld_nxt  = 1'b0;
        end
      end

      S_FILL: begin
        if (!stall_in) begin
          if (rd_ptr < ROWS) begin
            rd_en      = 1'b1;
            rd_addr    = ADDR_W'(rd_ptr);
            rd_ptr_nxt = rd_ptr + 1'b1;
          end
          // The hold register and a returning read never coincide, because
          // nothing is issued while stalled, so simple priority is enough.
          if (hold_vld) begin
            push_row     = 1'b1;
            fifo_d       = hold_q;
            hold_vld_nxt = 1'b0;
          end else if (rd_vld) begin
            push_row = 1'b1;
            fifo_d   = rd_data;
          end
          if (push_row) begin
            fifo_en      = 1'b1;
            push_cnt_nxt = push_cnt + 1'b1;
            if (push_cnt == LAST_ROW) state_nxt = S_DRAIN;
          end
        end else if (rd_vld) begin
          hold_vld_nxt = 1'b1;
          hold_nxt     = rd_data;
        end
      end

      S_DRAIN: begin
        if (!stall_in) begin
          fifo_en       = 1'b1;
          drain_cnt_nxt = drain_cnt + 1'b1;
          if (drain_cnt == LAST_DRAIN) state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  assign fifo_stall = stall_in;
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

endmodule

// File: doc/skew_feed_ctrl.md
# skew_feed_ctrl

Sequencer for the bank of delay FIFOs that skews operand rows into the systolic array. On `start` it reads `DIM` row vectors from operand memory and pushes one row per shift into the FIFO bank. It then pushes `DRAIN` zero rows so every lane empties, and pulses `done`. It is the only source of the bank's `en`, `stall` and `d` inputs, and it honours downstream back-pressure without losing in-flight memory data.

## Interface
- `DIM`, 8: lanes per row, rows per operand block.
- `BITS`, 8: bits per lane element.
- `ADDR_W`, 3: row-address width; must satisfy 2^`ADDR_W` ≥ `DIM`.
- `DRAIN`, 15: zero pushes after the last row (default 2*`DIM`-1).
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a block. Sampled only in IDLE; ignored otherwise.
- `stall_in` in 1: downstream back-pressure.
- `rd_en` out 1: operand memory read strobe.
- `rd_addr` out `ADDR_W`: row address. Valid while `rd_en`=1.
- `rd_data` in `DIM*BITS`: row data, valid exactly 1 cycle after `rd_en`. Lane i is at bits [i*BITS +: BITS].
- `fifo_en` out 1: shift strobe to every FIFO in the bank.
- `fifo_stall` out 1: stall to every FIFO in the bank.
- `fifo_d` out `DIM*BITS`: row pushed into the bank, using the same lane packing as `rd_data`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a block.

## Operation
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE → FILL when `start`=1. Clear `rd_ptr` (rows requested) and `push_cnt` (rows pushed).
- FILL, read issue:
  - `rd_en`=1 with `rd_addr`=`rd_ptr` when `stall_in`=0 and `rd_ptr`<`DIM`.
  - `rd_ptr` increments on each issue.
  - No read issues while `stall_in`=1.
- FILL, returning data (`rd_data` valid):
  - If `stall_in`=0: push it directly.
  - If `stall_in`=1: capture it in a one-entry hold register (`hold_vld`=1).
- FILL, push priority:
  - When `stall_in`=0 and `hold_vld`=1: push the hold register and clear `hold_vld`. A new read may issue in the same cycle.
  - Returning data and `hold_vld`=1 never coincide, because no read issues during stall.
- Push definition: `fifo_en`=1 and `fifo_d`=row for that cycle; `push_cnt` increments.
- FILL → DRAIN on the cycle the `DIM`-th row is pushed.
- DRAIN:
  - Each cycle with `stall_in`=0: `fifo_en`=1, `fifo_d`=0, increment `drain_cnt`.
  - Stalled cycles do not count.
  - → DONE after `DRAIN` zero pushes.
- DONE: `done`=1 for one cycle, then → IDLE. `start` is ignored in DONE.
- `fifo_stall` = `stall_in` (combinational) in every state.
- `fifo_en` = 0 whenever `stall_in`=1 and in IDLE/DONE.
- `fifo_d` = 0 whenever `fifo_en`=0.
- Counter widths: `rd_ptr` and `push_cnt` are $clog2(`DIM`+1) bits; `drain_cnt` is $clog2(`DRAIN`+1) bits. No wrap occurs within a block.
- `rst`=1 at any point, including mid-FILL or mid-DRAIN:
  - Next state is IDLE; all counters and `hold_vld` clear.
  - No `done` pulse is produced.
  - A read returning after reset is discarded.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `fifo_en`=0, `fifo_stall`=`stall_in`, `fifo_d`=0, `busy`=0, `done`=0.
- No-stall schedule, with `start` sampled at cycle 0:
  - Cycles 1..`DIM`: `rd_en`=1 with addresses 0..`DIM`-1.
  - Cycles 2..`DIM`+1: pushes of rows 0..`DIM`-1.
  - Cycles `DIM`+2..`DIM`+1+`DRAIN`: zero pushes.
  - Cycle `DIM`+2+`DRAIN`: `done`=1.
  - Cycle `DIM`+3+`DRAIN`: `busy`=0.
- Each stalled cycle extends the block by exactly one cycle. Row order and count are unchanged.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`.

## Test plan
- DIM=8, DRAIN=15, no stall, memory row r = all lanes r+1, `start` at cycle 0 → pushes 1..8 at cycles 2..9, 15 zero pushes at 10..24, `done` at 26? no: `done` at cycle 25, exactly 23 `fifo_en` pulses.
- `stall_in`=1 for cycles 4..6 → `rd_data` for row 2 (arriving cycle 4) is held in the hold register; row 2 pushes at cycle 7; `done` at cycle 28; push order is still 1..8.
- `stall_in` held high for the entire DRAIN phase for 5 cycles → exactly 15 zero pushes still occur; `done` slips by 5 cycles; `fifo_stall` tracks `stall_in` every cycle.
- `rst`=1 at cycle 5 of FILL → cycle 6 outputs all at reset values, `busy`=0, no `done`; a new `start` then reproduces the first scenario exactly.
- `start` pulsed during FILL, DRAIN and DONE → ignored; a `start` in IDLE after `done` launches a second block with identical timing.
